// File: rtl/risc_fetch_if.sv
// Bus bundle between the instruction unit and whoever drives it (bench or top).
// master drives program load and run control; slave is the fetch unit itself.
// Control handshake: prog_we, start and stall are level-sampled on each rising
// clock edge with no acknowledge; instr is meaningful to the decoder only in
// cycles where instr_valid is high, and each such cycle is a new instruction.
interface risc_fetch_if #(
    parameter int IW = 16,
    parameter int AW = 4
);
    logic          prog_we;
    logic [AW-1:0] prog_addr;
    logic [IW-1:0] prog_data;
    logic          start;
    logic [AW-1:0] end_addr;
    logic          stall;
    logic [IW-1:0] instr;
    logic          instr_valid;
    logic [AW-1:0] pc;
    logic          busy;
    logic          done;
    logic [1:0]    state_dbg;

    modport master (
        output prog_we, prog_addr, prog_data, start, end_addr, stall,
        input  instr, instr_valid, pc, busy, done, state_dbg
    );

    modport slave (
        input  prog_we, prog_addr, prog_data, start, end_addr, stall,
        output instr, instr_valid, pc, busy, done, state_dbg
    );
endinterface

// File: rtl/risc_fetch.sv
// Instruction unit: small writable instruction memory plus a program counter.
// Issues one registered instruction word per cycle to the decoder between a
// start and the latched end address, with stall support and a done flag.
module risc_fetch #(
    parameter int IW = 16,
    parameter int AW = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    risc_fetch_if.slave  bus
);
    localparam int DEPTH = 2 ** AW;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [AW-1:0] end_l_q, end_l_d;
    logic [IW-1:0] instr_q, instr_d;
    logic          instr_valid_q, instr_valid_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    // Memory is deliberately not reset so a loaded program survives rst_n.
    logic [IW-1:0] mem [DEPTH];

    // Program load port; writes are dropped while a program is running.
    always_ff @(posedge clk) begin
        if (bus.prog_we && (state_q != S_FETCH)) begin
            mem[bus.prog_addr] <= bus.prog_data;
        end
    end

    // Next-state logic: issue/advance in FETCH, start from IDLE or DONE.
    // done rises one cycle after the last issue so that cycle still shows
    // the final instruction as valid with done low.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        end_l_d       = end_l_q;
        instr_d       = instr_q;
        instr_valid_d = 1'b0;
        done_d        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_FETCH;
                    pc_d    = '0;
                    end_l_d = bus.end_addr;
                end
            end
            S_FETCH: begin
                if (!bus.stall) begin
                    instr_d       = mem[pc_q];
                    instr_valid_d = 1'b1;
                    // Entering DONE before the increment means pc never wraps.
                    if (pc_q == end_l_q) begin
                        state_d = S_DONE;
                    end else begin
                        pc_d = pc_q + AW'(1);
                    end
                end
            end
            S_DONE: begin
                if (bus.start) begin
                    state_d = S_FETCH;
                    pc_d    = '0;
                    end_l_d = bus.end_addr;
                end else begin
                    done_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d == S_FETCH);
    end

    // Control state and registered outputs; reset aborts any run immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            pc_q          <= '0;
            end_l_q       <= '0;
            instr_q       <= '0;
            instr_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            end_l_q       <= end_l_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign bus.instr       = instr_q;
    assign bus.instr_valid = instr_valid_q;
    assign bus.pc          = pc_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.state_dbg   = state_q;
endmodule

// File: tb/tb_risc_fetch.sv
// Directed bench for risc_fetch: issued instructions are checked against an
// expected queue filled when each run is started.
module tb_risc_fetch;
    localparam int IW = 16;
    localparam int AW = 4;

    logic clk;
    logic rst_n;

    risc_fetch_if #(.IW(IW), .AW(AW)) bus ();

    risc_fetch #(.IW(IW), .AW(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int issue_cnt = 0;
    logic [IW-1:0] exp_q[$];
    logic [IW-1:0] tb_mem [16];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // scoreboard: every issued word must match the head of the queue
    always @(negedge clk) begin
        if (bus.instr_valid === 1'b1) begin
            issue_cnt++;
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $error("FAIL unexpected_issue: observed %0h expected none", bus.instr);
            end else begin
                check("issued_instr", 32'(bus.instr), 32'(exp_q.pop_front()));
            end
        end
    end

    // driver tasks (all entered just after a falling edge)
    task automatic write_word(input logic [AW-1:0] a, input logic [IW-1:0] d);
        bus.prog_we   = 1'b1;
        bus.prog_addr = a;
        bus.prog_data = d;
        tb_mem[a]     = d;
        @(negedge clk);
        bus.prog_we   = 1'b0;
    endtask

    task automatic start_run(input logic [AW-1:0] e);
        for (int i = 0; i <= int'(e); i++) exp_q.push_back(tb_mem[i]);
        bus.end_addr = e;
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start    = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) break;
        end
        check(tag, 32'(bus.done), 32'd1);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_pc"},    32'(bus.pc),          32'd0);
        check({tag, "_instr"}, 32'(bus.instr),       32'd0);
        check({tag, "_valid"}, 32'(bus.instr_valid), 32'd0);
        check({tag, "_busy"},  32'(bus.busy),        32'd0);
        check({tag, "_done"},  32'(bus.done),        32'd0);
        check({tag, "_state"}, 32'(bus.state_dbg),   32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        logic [AW-1:0] pcs [4];
        pcs[0] = 4'd1; pcs[1] = 4'd2; pcs[2] = 4'd3; pcs[3] = 4'd3;

        rst_n         = 1'b0;
        bus.prog_we   = 1'b0;
        bus.prog_addr = '0;
        bus.prog_data = '0;
        bus.start     = 1'b0;
        bus.end_addr  = '0;
        bus.stall     = 1'b0;
        repeat (2) @(negedge clk);
        check_outputs_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // load program
        write_word(4'd0, 16'h1250);
        write_word(4'd1, 16'h2698);
        write_word(4'd2, 16'hE307);
        write_word(4'd3, 16'hF1C5);

        // plain run of four instructions
        base = issue_cnt;
        start_run(4'd3);
        check("run1_busy", 32'(bus.busy), 32'd1);
        check("run1_pc0",  32'(bus.pc),   32'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("run1_pc",    32'(bus.pc),          32'(pcs[k]));
            check("run1_valid", 32'(bus.instr_valid), 32'd1);
        end
        check("run1_done_late", 32'(bus.done), 32'd0);
        @(negedge clk);
        check("run1_done",  32'(bus.done),        32'd1);
        check("run1_busy0", 32'(bus.busy),        32'd0);
        check("run1_valid0",32'(bus.instr_valid), 32'd0);
        check("run1_instr", 32'(bus.instr),       32'h0000F1C5);
        check("run1_count", 32'(issue_cnt - base), 32'd4);
        // stall in DONE has no effect
        bus.stall = 1'b1;
        repeat (2) @(negedge clk);
        bus.stall = 1'b0;
        check("done_stall_done",  32'(bus.done),  32'd1);
        check("done_stall_instr", 32'(bus.instr), 32'h0000F1C5);

        // stalled run: two stall cycles after the second issue
        start_run(4'd3);
        repeat (2) @(negedge clk);
        check("stall_pc_before", 32'(bus.pc), 32'd2);
        bus.stall = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("stall_valid", 32'(bus.instr_valid), 32'd0);
            check("stall_instr", 32'(bus.instr),       32'h00002698);
            check("stall_pc",    32'(bus.pc),          32'd2);
        end
        bus.stall = 1'b0;
        @(negedge clk);
        check("resume_instr", 32'(bus.instr), 32'h0000E307);
        check("resume_pc",    32'(bus.pc),    32'd3);
        @(negedge clk);
        check("stall_done_late", 32'(bus.done), 32'd0);
        @(negedge clk);
        check("stall_done", 32'(bus.done), 32'd1);

        // single-instruction run
        base = issue_cnt;
        start_run(4'd0);
        wait_done("end0_done");
        check("end0_count", 32'(issue_cnt - base), 32'd1);
        check("end0_pc",    32'(bus.pc),           32'd0);

        // full memory run
        for (int i = 4; i < 16; i++) write_word(AW'(i), IW'($urandom_range(0, 16'hFFFF)));
        base = issue_cnt;
        start_run(4'd15);
        wait_done("full_done");
        check("full_count", 32'(issue_cnt - base), 32'd16);
        check("full_pc",    32'(bus.pc),           32'd15);

        // writes and start during FETCH are ignored
        base = issue_cnt;
        start_run(4'd3);
        bus.prog_we   = 1'b1;
        bus.prog_addr = 4'd2;
        bus.prog_data = 16'hFFFF;
        bus.start     = 1'b1;
        bus.end_addr  = 4'd1;
        @(negedge clk);
        bus.prog_we   = 1'b0;
        bus.start     = 1'b0;
        wait_done("fetchwr_done");
        check("fetchwr_count", 32'(issue_cnt - base), 32'd4);
        check("fetchwr_pc",    32'(bus.pc),           32'd3);
        start_run(4'd3);
        wait_done("fetchwr_rerun_done");

        // reset in the middle of a run
        start_run(4'd3);
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("midreset");
        exp_q.delete();
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("midreset_idle_state", 32'(bus.state_dbg), 32'd0);
        base = issue_cnt;
        start_run(4'd3);
        wait_done("rerun_done");
        check("rerun_count", 32'(issue_cnt - base), 32'd4);

        // restart from DONE with a shorter program; start beats stall
        base = issue_cnt;
        bus.stall = 1'b1;
        start_run(4'd1);
        bus.stall = 1'b0;
        check("restart_busy", 32'(bus.busy), 32'd1);
        check("restart_done0", 32'(bus.done), 32'd0);
        wait_done("restart_done");
        check("restart_count", 32'(issue_cnt - base), 32'd2);
        check("restart_pc",    32'(bus.pc),           32'd1);

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/risc_fetch.md
Name: risc_fetch

Overview:
- Instruction unit (IU) that feeds risc_decode.
- Holds a small writable instruction memory and a program counter, and issues one registered instruction word per cycle on instr.
- Supports a run/stall/done control flow, so a bench or top level can load a program, start it and detect completion.
- Its instr output connects directly to risc_decode's instr input.

Parameters:
- IW, 16, instruction word width. Fields: opcode instr[15:12]; ALU: dst[11:9], opnda[8:6], opndb[5:3]; ld (4'b1110): dst[11:9], dmaddr[3:0]; st (4'b1111): opnda[8:6], dmaddr[3:0].
- AW, 4, instruction memory address width; depth = 2**AW.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- prog_we  in  1  program write strobe; honoured only when not in FETCH.
- prog_addr  in  AW  program write address.
- prog_data  in  IW  program write data.
- start  in  1  begin execution at address 0; honoured in IDLE and DONE only.
- end_addr  in  AW  address of the last instruction; latched when start is accepted.
- stall  in  1  hold fetch; PC and instr frozen.
- instr  out  IW  registered instruction word to decoder.
- instr_valid  out  1  instr holds a newly issued instruction this cycle.
- pc  out  AW  address of the next instruction to issue.
- busy  out  1  high in FETCH.
- done  out  1  high in DONE.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE; pc, instr, instr_valid, busy, done and the latched end address all go to 0.
  - Memory contents are not reset and survive reset.
- Memory:
  - Synchronous write: mem[prog_addr] <= prog_data on a clock edge with prog_we=1 and state != FETCH.
  - prog_we in FETCH is silently dropped.
  - Read is combinational from pc into the instr register.
- States: IDLE, FETCH, DONE. busy and done are registered, set with the state update.
- IDLE:
  - instr_valid=0.
  - start=1 -> FETCH, pc<=0, end_l<=end_addr.
- FETCH, stall=0:
  - instr<=mem[pc], instr_valid<=1.
  - If pc==end_l: state<=DONE, pc held.
  - Else pc<=pc+1.
- FETCH, stall=1:
  - pc, instr and state held; instr_valid<=0.
  - The decoder re-registers the same word, which is harmless.
- DONE:
  - instr_valid<=0, done=1, instr keeps the last word.
  - start=1 -> FETCH with pc<=0 and a new end_l.
- Latency:
  - start sampled at edge N -> first instr/instr_valid visible after edge N+1.
  - Instruction k is issued after edge N+1+k plus the number of stall cycles.
  - done rises after the edge following the last issue.
- Boundaries:
  - end_addr=0 issues exactly one instruction.
  - end_addr=2**AW-1 issues the full memory; pc never wraps, because DONE is entered before incrementing.
  - start in FETCH is ignored; end_addr changes mid-run are ignored because end_l is used.
  - stall in IDLE or DONE has no effect.
  - stall and start together in IDLE or DONE: start wins.
  - rst_n low mid-run aborts immediately to IDLE with outputs 0; the program is retained, so a new start re-runs it.

Test Plan:
- Load mem[0..3]=16'h1250,16'h2698,16'hE307,16'hF1C5; end_addr=3; pulse start -> instr shows those 4 words on 4 consecutive cycles with instr_valid=1, pc 1,2,3,3, then done=1, busy=0, instr_valid=0, instr=16'hF1C5.
- Same program; stall=1 for 2 cycles after the second issue -> instr stays 16'h2698 with instr_valid=0 for 2 cycles, pc=2; issue resumes with 16'hE307; done arrives 2 cycles later than the unstalled run.
- end_addr=0, start -> exactly one issue of mem[0], then DONE; end_addr=15 with all 16 words written -> 16 issues, pc ends at 15, no wrap.
- During FETCH: prog_we=1, prog_addr=2, data=16'hFFFF, plus start=1 and end_addr=1 -> mem[2] unchanged on the next run, run still ends at 3, no restart.
- Assert rst_n=0 after the second issue -> outputs go to 0 asynchronously, state IDLE; after release, start -> the same 4 words are re-issued from address 0.
- From DONE, start with end_addr=1 -> mem[0], mem[1] issued, done again.
